// File: rtl/spi_master_controller_if.sv
// Handshake, configuration and SPI pin bundle for spi_master_controller.
// The controller connects through the slave modport; the requester or bench uses master.
interface spi_master_controller_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DIV_WIDTH  = 8
);
  logic                  tx_valid;
  logic                  tx_ready;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  cpol;
  logic                  cpha;
  logic                  lsb_first;
  logic [DIV_WIDTH-1:0]  baud_div;
  logic                  rx_valid;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  busy;
  logic                  sclk;
  logic                  cs;
  logic                  mosi0;
  logic                  miso0;

  modport master (
    output tx_valid, tx_data, cpol, cpha, lsb_first, baud_div, miso0,
    input  tx_ready, rx_valid, rx_data, busy, sclk, cs, mosi0
  );

  modport slave (
    input  tx_valid, tx_data, cpol, cpha, lsb_first, baud_div, miso0,
    output tx_ready, rx_valid, rx_data, busy, sclk, cs, mosi0
  );
endinterface

// File: rtl/spi_master_controller.sv
// Single-lane SPI master: one word per valid/ready accept, all four CPOL/CPHA modes,
// MSB- or LSB-first, received word returned with a one-cycle rx_valid pulse.
module spi_master_controller #(
  parameter int DATA_WIDTH = 8,
  parameter int DIV_WIDTH  = 8
) (
  input  logic                   pclk,
  input  logic                   areset,
  spi_master_controller_if.slave bus
);
  localparam int EDGE_W = $clog2(2*DATA_WIDTH) + 1;
  localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2*DATA_WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_XFER, S_HOLD} state_t;

  state_t                r_state, w_next_state;
  logic [DATA_WIDTH-1:0] r_tx, r_rx, r_rx_data;
  logic [DIV_WIDTH-1:0]  r_cnt, r_div;
  logic [EDGE_W-1:0]     r_edge, w_edge_nxt;
  logic                  r_cpha, r_lsb, r_sclk, r_cs, r_mosi, r_rx_valid;
  logic                  w_accept, w_cnt_zero, w_toggle, w_leading, w_last;
  logic                  w_sample, w_drive;

  function automatic logic first_bit(input logic [DATA_WIDTH-1:0] d, input logic lsb);
    return lsb ? d[0] : d[DATA_WIDTH-1];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] shift_out(input logic [DATA_WIDTH-1:0] d,
                                                      input logic lsb);
    return lsb ? (d >> 1) : (d << 1);
  endfunction

  // Received bits land in the same order they were transmitted.
  function automatic logic [DATA_WIDTH-1:0] shift_in(input logic [DATA_WIDTH-1:0] d,
                                                     input logic b, input logic lsb);
    return lsb ? {b, d[DATA_WIDTH-1:1]} : {d[DATA_WIDTH-2:0], b};
  endfunction

  assign w_accept   = bus.tx_valid && (r_state == S_IDLE);
  assign w_cnt_zero = (r_cnt == '0);
  assign w_edge_nxt = r_edge + 1'b1;
  assign w_toggle   = w_cnt_zero && ((r_state == S_SETUP) || (r_state == S_XFER));
  assign w_leading  = w_edge_nxt[0];
  assign w_last     = (w_edge_nxt == LAST_EDGE);
  assign w_sample   = w_toggle && (r_cpha ? !w_leading : w_leading);
  assign w_drive    = w_toggle && (r_cpha ? w_leading : (!w_leading && !w_last));

  always_ff @(posedge pclk or negedge areset) begin
    if (!areset) r_state <= S_IDLE;
    else         r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_accept)             w_next_state = S_SETUP;
      S_SETUP: if (w_cnt_zero)           w_next_state = S_XFER;
      S_XFER:  if (w_cnt_zero && w_last) w_next_state = S_HOLD;
      S_HOLD:  if (w_cnt_zero)           w_next_state = S_IDLE;
      default:                           w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge areset) begin
    if (!areset) begin
      r_tx       <= '0;
      r_rx       <= '0;
      r_rx_data  <= '0;
      r_cnt      <= '0;
      r_div      <= '0;
      r_edge     <= '0;
      r_cpha     <= 1'b0;
      r_lsb      <= 1'b0;
      r_sclk     <= 1'b0;
      r_cs       <= 1'b1;
      r_mosi     <= 1'b0;
      r_rx_valid <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cs   <= 1'b1;
          r_mosi <= 1'b0;
          r_sclk <= bus.cpol;
          if (w_accept) begin
            r_cs   <= 1'b0;
            r_cpha <= bus.cpha;
            r_lsb  <= bus.lsb_first;
            r_div  <= bus.baud_div;
            r_cnt  <= bus.baud_div;
            r_edge <= '0;
            r_rx   <= '0;
            // With cpha=0 the first bit must be on the line before the first leading edge.
            if (!bus.cpha) begin
              r_mosi <= first_bit(bus.tx_data, bus.lsb_first);
              r_tx   <= shift_out(bus.tx_data, bus.lsb_first);
            end else begin
              r_tx   <= bus.tx_data;
            end
          end
        end
        S_SETUP, S_XFER: begin
          if (w_toggle) begin
            r_cnt  <= r_div;
            r_sclk <= ~r_sclk;
            r_edge <= w_edge_nxt;
          end else begin
            r_cnt  <= r_cnt - 1'b1;
          end
          if (w_sample) r_rx <= shift_in(r_rx, bus.miso0, r_lsb);
          if (w_drive) begin
            r_mosi <= first_bit(r_tx, r_lsb);
            r_tx   <= shift_out(r_tx, r_lsb);
          end
        end
        S_HOLD: begin
          if (w_cnt_zero) begin
            r_cs       <= 1'b1;
            r_mosi     <= 1'b0;
            r_rx_valid <= 1'b1;
            r_rx_data  <= r_rx;
          end else begin
            r_cnt      <= r_cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.tx_ready = (r_state == S_IDLE);
  assign bus.busy     = (r_state != S_IDLE);
  assign bus.sclk     = r_sclk;
  assign bus.cs       = r_cs;
  assign bus.mosi0    = r_mosi;
  assign bus.rx_valid = r_rx_valid;
  assign bus.rx_data  = r_rx_data;
endmodule

// File: tb/tb_spi_master_controller.sv
// Scoreboard bench for spi_master_controller: a behavioural SPI slave plus
// an rx_valid monitor, both checked against per-word expectations queued at accept.
module tb_spi_master_controller;
  localparam int DW = 8;
  localparam int VW = 8;
  localparam int N2 = 2*DW;

  logic pclk = 1'b0;
  logic areset = 1'b0;
  always #5 pclk = ~pclk;

  spi_master_controller_if #(.DATA_WIDTH(DW), .DIV_WIDTH(VW)) bus ();
  spi_master_controller #(.DATA_WIDTH(DW), .DIV_WIDTH(VW)) dut (
    .pclk(pclk), .areset(areset), .bus(bus)
  );

  typedef struct { logic [7:0] rx; int cyc; logic cpol; } exp_t;
  typedef struct { logic [7:0] tx; logic [7:0] sw; logic cpol; logic cpha; logic lsb; } cfg_t;

  exp_t exp_q[$];
  cfg_t cfg_q[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rx_last = -1, rx_prev = -1;
  int cs_run = 0, last_gap = 0;
  bit abort = 1'b0;

  always @(posedge pclk) cyc <= cyc + 1;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic sbit(input logic [7:0] w, input int i, input bit lsb);
    return lsb ? w[i] : w[7-i];
  endfunction

  // rx_valid monitor
  exp_t mon_e;
  always @(negedge pclk) begin
    if (areset && bus.rx_valid) begin
      rx_prev = rx_last;
      rx_last = cyc;
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL rx_unexpected actual=rx_valid expected=none (cycle %0d)", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check("rx_data", bus.rx_data, mon_e.rx);
        check("rx_latency", cyc, mon_e.cyc);
        check("sclk_idle", bus.sclk, mon_e.cpol);
        check("cs_done", bus.cs, 1);
      end
    end
  end

  always @(negedge pclk) begin
    if (bus.cs) cs_run++;
    else begin
      if (cs_run > 0) last_gap = cs_run;
      cs_run = 0;
    end
  end

  // Behavioural SPI slave: returns cfg.sw, captures mosi0 at its sampling edges
  cfg_t sl_cfg;
  bit   sl_active = 1'b0;
  int   sl_edges = 0, sl_didx = 0, sl_sidx = 0;
  logic [7:0] sl_cap;
  logic prev_sclk = 1'b0, prev_mosi = 1'b0;
  bit   sl_lead, sl_samp;
  always @(negedge pclk) begin
    if (bus.cs !== 1'b0) begin
      if (sl_active) begin
        if (sl_edges == N2) check("mosi_word", sl_cap, sl_cfg.tx);
        else if (!abort) begin
          checks++; failures++;
          $display("FAIL sclk_edges actual=%0d expected=%0d", sl_edges, N2);
        end
      end
      sl_active = 1'b0;
      bus.miso0 = 1'b0;
    end else if (!sl_active) begin
      if (cfg_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL cs_unexpected actual=cs_low expected=cs_high (cycle %0d)", cyc);
        sl_cfg = '{8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
      end else begin
        sl_cfg = cfg_q.pop_front();
      end
      sl_active = 1'b1;
      sl_edges = 0; sl_didx = 0; sl_sidx = 0; sl_cap = 8'h00;
      check("sclk_setup", bus.sclk, sl_cfg.cpol);
      if (!sl_cfg.cpha) begin
        bus.miso0 = sbit(sl_cfg.sw, 0, sl_cfg.lsb);
        sl_didx = 1;
      end
    end else if (bus.sclk !== prev_sclk) begin
      sl_edges++;
      sl_lead = sl_edges[0];
      sl_samp = sl_cfg.cpha ? !sl_lead : sl_lead;
      if (sl_samp) begin
        check("mosi_stable", bus.mosi0, prev_mosi);
        if (sl_sidx < DW) sl_cap[sl_cfg.lsb ? sl_sidx : 7-sl_sidx] = bus.mosi0;
        sl_sidx++;
      end else if (sl_didx < DW) begin
        bus.miso0 = sbit(sl_cfg.sw, sl_didx, sl_cfg.lsb);
        sl_didx++;
      end
    end
    prev_sclk = bus.sclk;
    prev_mosi = bus.mosi0;
  end

  // Present a word; returns just after the accepting edge.
  task automatic send(input logic [7:0] d, input logic [7:0] sw, input bit pol, input bit pha,
                      input bit lsb, input logic [7:0] div, input bit keep);
    int n = 0;
    @(negedge pclk);
    bus.tx_valid = 1'b1; bus.tx_data = d; bus.cpol = pol; bus.cpha = pha;
    bus.lsb_first = lsb; bus.baud_div = div;
    while (!bus.tx_ready && n < 300) begin @(negedge pclk); n++; end
    if (!bus.tx_ready) begin
      checks++; failures++;
      $display("FAIL accept_timeout actual=tx_ready_low expected=tx_ready_high");
      bus.tx_valid = 1'b0;
      return;
    end
    cfg_q.push_back('{d, sw, pol, pha, lsb});
    exp_q.push_back('{sw, cyc + 1 + (N2 + 1) * (int'(div) + 1), pol});
    @(posedge pclk);
    if (!keep) begin
      // Scramble the inputs while busy; the transfer must ignore them.
      @(negedge pclk);
      bus.tx_valid = 1'b0; bus.tx_data = 8'($urandom); bus.cpol = 1'($urandom);
      bus.cpha = 1'($urandom); bus.lsb_first = 1'($urandom); bus.baud_div = 8'($urandom);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || !bus.tx_ready) && n < 1000) begin @(negedge pclk); n++; end
    if (exp_q.size() != 0 || !bus.tx_ready) begin
      checks++; failures++;
      $display("FAIL idle_timeout actual=pending%0d expected=pending0", exp_q.size());
    end
    repeat (2) @(negedge pclk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.tx_valid = 1'b0; bus.tx_data = 8'h00; bus.cpol = 1'b0; bus.cpha = 1'b0;
    bus.lsb_first = 1'b0; bus.baud_div = 8'h00;
    areset = 1'b0;
    repeat (3) @(negedge pclk);
    check("rst_cs", bus.cs, 1);
    check("rst_sclk", bus.sclk, 0);
    check("rst_mosi", bus.mosi0, 0);
    check("rst_rx_valid", bus.rx_valid, 0);
    check("rst_rx_data", bus.rx_data, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_tx_ready", bus.tx_ready, 1);
    areset = 1'b1;

    send(8'hA5, 8'h3C, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);   // mode 0, MSB-first, 18-cycle latency
    wait_idle();
    send(8'h81, 8'h0F, 1'b1, 1'b1, 1'b1, 8'd3, 1'b0);   // mode 3, LSB-first, 69-cycle latency
    wait_idle();
    send(8'h5A, 8'hC3, 1'b0, 1'b1, 1'b0, 8'd1, 1'b0);   // mode 1
    send(8'h5A, 8'hC3, 1'b1, 1'b0, 1'b0, 8'd1, 1'b0);   // mode 2
    wait_idle();

    // Back-to-back with tx_valid held: pulses 18 cycles apart, 17 cycles between them
    send(8'h11, 8'h96, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1);
    send(8'h22, 8'h69, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    wait_idle();
    check("b2b_cs_gap", last_gap, 1);
    check("b2b_rx_spacing", rx_last - rx_prev, 18);

    // Asynchronous reset in the middle of a word
    send(8'hA5, 8'h3C, 1'b0, 1'b0, 1'b0, 8'd1, 1'b0);
    n = 0;
    while (sl_edges < 5 && n < 300) begin @(negedge pclk); #1; n++; end
    check("abort_reached_edge5", (sl_edges >= 5) ? 1 : 0, 1);
    abort = 1'b1;
    areset = 1'b0;
    #1;
    check("abort_cs", bus.cs, 1);
    check("abort_sclk", bus.sclk, 0);
    check("abort_mosi", bus.mosi0, 0);
    check("abort_rx_valid", bus.rx_valid, 0);
    check("abort_busy", bus.busy, 0);
    exp_q.delete();
    cfg_q.delete();
    repeat (3) @(negedge pclk);
    areset = 1'b1;
    repeat (2) @(negedge pclk);
    abort = 1'b0;
    send(8'hA5, 8'h3C, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    wait_idle();

    for (int i = 0; i < 24; i++) begin
      send(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
           8'($urandom_range(0, 3)), 1'b0);
    end
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
